// File: rtl/tiny_nn_seq_if.sv
// Word type and host-side handshake bundle (command, data, result) for the tiny_nn_seq sequencer.
package tiny_nn_seq_pkg;
   typedef logic [15:0] fp_t;
endpackage

interface tiny_nn_seq_if;
   import tiny_nn_seq_pkg::*;

   logic       cmd_valid_i;
   logic       cmd_ready_o;
   logic [1:0] cmd_op_i;
   logic       data_valid_i;
   logic       data_ready_o;
   fp_t        data_i;
   logic       res_valid_o;
   logic       res_ready_i;
   fp_t        res_o;

   modport slave (
      input  cmd_valid_i, cmd_op_i, data_valid_i, data_i, res_ready_i,
      output cmd_ready_o, data_ready_o, res_valid_o, res_o
   );

   modport master (
      output cmd_valid_i, cmd_op_i, data_valid_i, data_i, res_ready_i,
      input  cmd_ready_o, data_ready_o, res_valid_o, res_o
   );
endinterface

// File: rtl/tiny_nn_seq.sv
// Sequencer driving a 4x2 multiply/accumulate core: loads params/values, runs a dot product.
// Strobes appear one cycle after each accepted word; result valid 7 cycles after COMPUTE, held until res_ready_i.
module tiny_nn_seq
   import tiny_nn_seq_pkg::*;
#(
   parameter int ValArrayWidth  = 4,
   parameter int ValArrayHeight = 2
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   tiny_nn_seq_if.slave        bus,
   output logic                busy_o,
   output fp_t                 core_val_o,
   output logic [1:0]          core_val_shift_o,
   output fp_t                 core_param_o,
   output logic [7:0]          core_param_write_o,
   output logic                core_mul_row_sel_o,
   output logic                core_mul_en_o,
   output logic                core_accumulate_en_o,
   input  fp_t                 core_accumulate_i
);

   if (ValArrayWidth != 4) begin : g_bad_width
      $error("tiny_nn_seq: ValArrayWidth must be 4");
   end
   if (ValArrayHeight != 2) begin : g_bad_height
      $error("tiny_nn_seq: ValArrayHeight must be 2");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_PARAM, S_LOAD_VAL, S_MUL, S_ACC, S_RESULT
   } state_e;

   state_e     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   fp_t        res_q, res_d;
   logic       res_vld_q, res_vld_d;
   fp_t        val_q, val_d;
   fp_t        param_q, param_d;
   logic [1:0] shift_q, shift_d;
   logic [7:0] write_q, write_d;
   logic       row_sel_q, row_sel_d;
   logic       mul_en_q, mul_en_d;
   logic       acc_en_q, acc_en_d;
   logic       cmd_fire, data_fire;

   assign bus.cmd_ready_o  = rst_ni && (state_q == S_IDLE);
   assign bus.data_ready_o = rst_ni && ((state_q == S_LOAD_PARAM) || (state_q == S_LOAD_VAL));
   assign cmd_fire         = bus.cmd_valid_i && bus.cmd_ready_o;
   assign data_fire        = bus.data_valid_i && bus.data_ready_o;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      res_d     = res_q;
      res_vld_d = res_vld_q;
      val_d     = val_q;
      param_d   = param_q;
      shift_d   = 2'b00;
      write_d   = 8'h00;
      row_sel_d = row_sel_q;
      mul_en_d  = 1'b0;
      acc_en_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_fire) begin
               cnt_d = 3'd0;
               unique case (bus.cmd_op_i)
                  2'b00: state_d = S_LOAD_PARAM;
                  2'b01: state_d = S_LOAD_VAL;
                  2'b10: begin
                     state_d   = S_MUL;
                     mul_en_d  = 1'b1;
                     row_sel_d = 1'b0;
                  end
                  default: state_d = S_IDLE;
               endcase
            end
         end
         S_LOAD_PARAM: begin
            if (data_fire) begin
               param_d = bus.data_i;
               write_d = 8'h01 << cnt_q;
               cnt_d   = cnt_q + 3'd1;
               if (cnt_q == 3'd7) state_d = S_IDLE;
            end
         end
         S_LOAD_VAL: begin
            if (data_fire) begin
               val_d   = bus.data_i;
               // First four words fill row 0, the rest row 1.
               shift_d = cnt_q[2] ? 2'b10 : 2'b01;
               cnt_d   = cnt_q + 3'd1;
               if (cnt_q == 3'd7) state_d = S_IDLE;
            end
         end
         S_MUL: begin
            if (cnt_q == 3'd0) begin
               mul_en_d  = 1'b1;
               row_sel_d = 1'b1;
               cnt_d     = 3'd1;
            end else begin
               acc_en_d = 1'b1;
               cnt_d    = 3'd0;
               state_d  = S_ACC;
            end
         end
         S_ACC: begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q < 3'd2) acc_en_d = 1'b1;
            // One idle cycle after the last accumulate lets the core output settle.
            if (cnt_q == 3'd3) begin
               res_d     = core_accumulate_i;
               res_vld_d = 1'b1;
               state_d   = S_RESULT;
            end
         end
         S_RESULT: begin
            if (bus.res_ready_i) begin
               res_vld_d = 1'b0;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         cnt_q     <= 3'd0;
         res_q     <= '0;
         res_vld_q <= 1'b0;
         val_q     <= '0;
         param_q   <= '0;
         shift_q   <= 2'b00;
         write_q   <= 8'h00;
         row_sel_q <= 1'b0;
         mul_en_q  <= 1'b0;
         acc_en_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         res_q     <= res_d;
         res_vld_q <= res_vld_d;
         val_q     <= val_d;
         param_q   <= param_d;
         shift_q   <= shift_d;
         write_q   <= write_d;
         row_sel_q <= row_sel_d;
         mul_en_q  <= mul_en_d;
         acc_en_q  <= acc_en_d;
      end
   end

   assign busy_o               = (state_q != S_IDLE);
   assign bus.res_o            = res_q;
   assign bus.res_valid_o      = res_vld_q;
   assign core_val_o           = val_q;
   assign core_val_shift_o     = shift_q;
   assign core_param_o         = param_q;
   assign core_param_write_o   = write_q;
   assign core_mul_row_sel_o   = row_sel_q;
   assign core_mul_en_o        = mul_en_q;
   assign core_accumulate_en_o = acc_en_q;

endmodule

// File: tb/tb_tiny_nn_seq.sv
// Directed bench for tiny_nn_seq with a Q8.8 behavioural model of the attached 4x2 core.
module tb_tiny_nn_seq;
   import tiny_nn_seq_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       busy;
   fp_t        core_val, core_param, core_acc;
   logic [1:0] core_shift;
   logic [7:0] core_write;
   logic       core_row, core_mul, core_accen;
   int         checks = 0;
   int         errors = 0;
   fp_t        words [8];

   always #5 clk = ~clk;

   tiny_nn_seq_if bus ();

   tiny_nn_seq #(.ValArrayWidth(4), .ValArrayHeight(2)) dut (
      .clk_i(clk), .rst_ni(rst_n), .bus(bus), .busy_o(busy),
      .core_val_o(core_val), .core_val_shift_o(core_shift),
      .core_param_o(core_param), .core_param_write_o(core_write),
      .core_mul_row_sel_o(core_row), .core_mul_en_o(core_mul),
      .core_accumulate_en_o(core_accen), .core_accumulate_i(core_acc)
   );

   // Core model: param bit x+4y, per-row value shift chain, per-row dot product, two-step accumulate.
   fp_t cm_param [8];
   fp_t cm_val   [2][4];
   fp_t cm_part  [2];
   int  cm_idx = 0;
   fp_t cm_acc = '0;
   assign core_acc = cm_acc;

   function automatic fp_t dot(input int r);
      int s = 0;
      for (int x = 0; x < 4; x++)
         s += (int'(cm_param[x + 4 * r]) * int'(cm_val[r][x])) >>> 8;
      return fp_t'(s);
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 8; i++)
         if (core_write[i]) cm_param[i] <= core_param;
      for (int r = 0; r < 2; r++)
         if (core_shift[r]) begin
            cm_val[r][0] <= core_val;
            for (int j = 1; j < 4; j++) cm_val[r][j] <= cm_val[r][j-1];
         end
      if (core_mul) begin
         cm_part[core_row] <= dot(int'(core_row));
         cm_idx <= 0;
      end
      if (core_accen) begin
         if (cm_idx == 0) cm_acc <= cm_part[0];
         else if (cm_idx == 1) cm_acc <= cm_acc + cm_part[1];
         cm_idx <= cm_idx + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [1:0] op, input bit gap);
      bus.cmd_valid_i = 1'b1;
      bus.cmd_op_i    = op;
      chk("ld_cmd_rdy", 32'(bus.cmd_ready_o), 32'd1);
      tick();
      bus.cmd_valid_i = 1'b0;
      chk("ld_busy", {busy, bus.data_ready_o, bus.cmd_ready_o}, 32'b110);
      for (int k = 0; k < 8; k++) begin
         bus.data_valid_i = 1'b1;
         bus.data_i       = words[k];
         tick();
         if (op == 2'b00) begin
            chk("ld_pwrite", 32'(core_write), 32'd1 << k);
            chk("ld_pdata", 32'(core_param), 32'(words[k]));
         end else begin
            chk("ld_vshift", 32'(core_shift), (k < 4) ? 32'd1 : 32'd2);
            chk("ld_vdata", 32'(core_val), 32'(words[k]));
         end
         chk("ld_cmd_rdy_k", 32'(bus.cmd_ready_o), (k == 7) ? 32'd1 : 32'd0);
         if (gap) begin
            bus.data_valid_i = 1'b0;
            bus.data_i       = 16'hdead;
            tick();
            chk("ld_stall_strobe", {core_write, core_shift}, 32'd0);
            chk("ld_stall_hold", (op == 2'b00) ? 32'(core_param) : 32'(core_val), 32'(words[k]));
         end
      end
      bus.data_valid_i = 1'b0;
      chk("ld_done_busy", 32'(busy), 32'd0);
   endtask

   // Issues COMPUTE and steps to C7; strobe pattern per cycle is {mul_en,row_sel,acc_en,res_valid}.
   task automatic run_to_result(input logic rdy);
      logic [3:0] exp_v;
      bus.res_ready_i = rdy;
      bus.cmd_valid_i = 1'b1;
      bus.cmd_op_i    = 2'b10;
      chk("cmp_cmd_rdy", 32'(bus.cmd_ready_o), 32'd1);
      tick();
      bus.cmd_valid_i = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         exp_v = {c <= 2, c >= 2, c >= 3 && c <= 5, 1'b0};
         chk($sformatf("cmp_c%0d", c), {core_mul, core_row, core_accen, bus.res_valid_o}, 32'(exp_v));
         chk("cmp_busy", {busy, bus.cmd_ready_o}, 32'b10);
         tick();
      end
      chk("cmp_c7_vld", {core_mul, core_accen, bus.res_valid_o}, 32'b001);
      chk("cmp_c7_res", 32'(bus.res_o), 32'h2400);
   endtask

   initial begin
      int cnt;
      rst_n = 1'b0;
      bus.cmd_valid_i = 1'b0;  bus.cmd_op_i = 2'b00;
      bus.data_valid_i = 1'b0; bus.data_i = '0;
      bus.res_ready_i = 1'b0;
      repeat (3) tick();
      chk("rst_ready", {bus.cmd_ready_o, bus.data_ready_o}, 32'd0);
      chk("rst_res", {bus.res_valid_o, busy, bus.res_o}, 32'd0);
      chk("rst_core", {core_write, core_shift, core_mul, core_row, core_accen}, 32'd0);
      chk("rst_coredat", {core_val, core_param}, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rst_rel_rdy", 32'(bus.cmd_ready_o), 32'd1);

      for (int k = 0; k < 8; k++) words[k] = 16'h1000 + fp_t'(k) * 16'h0111;
      do_load(2'b00, 1'b0);
      tick();
      chk("ld_idle_nowrite", 32'(core_write), 32'd0);
      for (int k = 0; k < 8; k++) words[k] = 16'h0100;
      do_load(2'b00, 1'b0);
      for (int k = 0; k < 8; k++) words[k] = fp_t'(k + 1) << 8;
      do_load(2'b01, 1'b1);

      run_to_result(1'b1);
      tick();
      chk("cmp_release", {bus.res_valid_o, busy, bus.cmd_ready_o}, 32'b001);
      chk("cmp_res_hold", 32'(bus.res_o), 32'h2400);

      run_to_result(1'b0);
      for (int i = 0; i < 10; i++) begin
         bus.cmd_valid_i = 1'b1;
         bus.cmd_op_i    = 2'b11;
         tick();
         chk("stall_vld", {bus.res_valid_o, busy, bus.cmd_ready_o}, 32'b110);
         chk("stall_res", 32'(bus.res_o), 32'h2400);
      end
      bus.cmd_valid_i = 1'b0;
      bus.res_ready_i = 1'b1;
      tick();
      chk("stall_release", {bus.res_valid_o, busy, bus.cmd_ready_o}, 32'b001);
      bus.res_ready_i = 1'b0;

      bus.cmd_valid_i = 1'b1;
      bus.cmd_op_i    = 2'b11;
      chk("op3_rdy", 32'(bus.cmd_ready_o), 32'd1);
      tick();
      bus.cmd_valid_i = 1'b0;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         if (busy || core_write != 0 || core_shift != 0 || core_mul || core_accen) cnt++;
         tick();
      end
      chk("op3_quiet", 32'(cnt), 32'd0);

      bus.res_ready_i = 1'b1;
      bus.cmd_valid_i = 1'b1;
      bus.cmd_op_i    = 2'b10;
      tick();
      bus.cmd_valid_i = 1'b0;
      tick();
      tick();
      chk("rstc3_acc", 32'(core_accen), 32'd1);
      rst_n = 1'b0;
      tick();
      chk("rstc3_quiet", {core_accen, core_mul, busy, bus.res_valid_o}, 32'd0);
      chk("rstc3_ready", {bus.cmd_ready_o, bus.data_ready_o}, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rstc3_idle", 32'(bus.cmd_ready_o), 32'd1);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (core_accen || bus.res_valid_o) cnt++;
         tick();
      end
      chk("rstc3_nopulse", 32'(cnt), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/tiny_nn_seq.md
TINY_NN_SEQ -- requirements
Module: tiny_nn_seq

Interface
REQ-001 Parameter ValArrayWidth, default 4: columns of the attached core; elaboration SHALL fail if not 4.
REQ-002 Parameter ValArrayHeight, default 2: rows of the attached core; elaboration SHALL fail if not 2.
REQ-003 clk_i  in  1  sole clock; all state updates on posedge.
REQ-004 rst_ni  in  1  reset, synchronous, active-low.
REQ-005 cmd_valid_i / cmd_ready_o  in/out  1/1  command handshake; transfer when both high on a posedge.
REQ-006 cmd_op_i  in  2  00 LOAD_PARAM, 01 LOAD_VAL, 10 COMPUTE, 11 reserved.
REQ-007 data_valid_i / data_ready_o  in/out  1/1  data-word handshake.
REQ-008 data_i  in  fp_t  parameter or value word.
REQ-009 res_valid_o / res_ready_i  out/in  1/1  result handshake.
REQ-010 res_o  out  fp_t  dot-product result.
REQ-011 busy_o  out  1  high whenever state is not IDLE.
REQ-012 core_val_o  out  fp_t;  core_val_shift_o  out  2  per-row shift enable.
REQ-013 core_param_o  out  fp_t;  core_param_write_o  out  8  one-hot write, bit x+4*y.
REQ-014 core_mul_row_sel_o, core_mul_en_o, core_accumulate_en_o  out  1 each.
REQ-015 core_accumulate_i  in  fp_t  core accumulator output.

Function
REQ-016 FSM states: IDLE, LOAD_PARAM, LOAD_VAL, MUL, ACC, RESULT; all core_* and res_* outputs registered.
REQ-017 cmd_ready_o high only in IDLE; data_ready_o high only in LOAD_PARAM and LOAD_VAL.
REQ-018 IDLE: LOAD_PARAM -> LOAD_PARAM, LOAD_VAL -> LOAD_VAL, COMPUTE -> MUL; word counter cleared to 0 on entry.
REQ-019 Op 11: accepted, no core activity, remain IDLE.
REQ-020 LOAD_PARAM: k-th accepted word (k=0..7) drives core_param_o=data_i and core_param_write_o=1<<k in the following cycle; all other cycles write=0.
REQ-021 LOAD_VAL: k-th accepted word drives core_val_o=data_i the following cycle, with core_val_shift_o=01 for k=0..3 and 10 for k=4..7; otherwise 00.
REQ-022 Loads: return to IDLE after the 8th word is accepted; no timeout; data_valid_i low stalls indefinitely without output activity.
REQ-023 COMPUTE accepted in cycle C0: C1 mul_en=1, row_sel=0; C2 mul_en=1, row_sel=1; C3-C5 accumulate_en=1; all three strobes 0 in all other cycles.
REQ-024 Result: res_o captures core_accumulate_i on the C6 posedge; res_valid_o=1 from C7 (state RESULT).
REQ-025 RESULT: res_o and res_valid_o hold until res_ready_i high on a posedge, then res_valid_o=0 and state is IDLE in the next cycle; no new command accepted before that.
REQ-026 res_ready_i is ignored while res_valid_o=0; data_valid_i is ignored outside load states.
REQ-027 core_mul_row_sel_o holds its last value when mul_en=0; core_val_o and core_param_o hold their last value when not strobed.

Reset
REQ-028 rst_ni low on a posedge: state=IDLE; counters=0; res_valid_o=0, res_o=0, busy_o=0; all core_* outputs 0.
REQ-029 Reset mid-operation aborts the load or compute with no further strobes; core contents are not restored; a pending result is discarded.
REQ-030 While rst_ni is low, cmd_ready_o=0 and data_ready_o=0.

Verification
REQ-031 LOAD_PARAM of 8 words P0..P7 with data_valid_i high throughout -> core_param_write_o 01,02,04,...,80 on 8 consecutive cycles carrying P0..P7, then IDLE.
REQ-032 LOAD_VAL with data_valid_i toggling every other cycle -> exactly 8 shift pulses: 4 on row 0, then 4 on row 1, carrying data in order; cmd_ready_o=0 until the 8th word.
REQ-033 Params all 1.0, values 1.0..8.0, COMPUTE with res_ready_i=1 -> strobes on C1..C5 as in REQ-023; res_valid_o at C7 with res_o=36.0 (via a core model).
REQ-034 COMPUTE with res_ready_i held low for 10 cycles -> res_o stable, cmd_ready_o=0, a second cmd_valid_i not accepted; release -> IDLE one cycle after.
REQ-035 rst_ni low in C3 of COMPUTE -> no further accumulate_en pulses, res_valid_o never asserted, IDLE with cmd_ready_o=1 once rst_ni is high.
REQ-036 Op 11 -> accepted in one cycle, zero core strobes, busy_o remains 0.
